// File: rtl/dma_copy_engine_if.sv
// DMA requester bus between the copy engine and the memory controller.
// The engine is the master (drives requests); the controller is the slave.
interface dma_copy_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_valid;

    modport master (
        output mem_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata, mem_valid
    );

    modport slave (
        input  mem_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata, mem_valid
    );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-at-a-time memory copy engine: read one word from SRC, write it to DST,
// repeat LEN times. Requests are level-held until the controller answers with
// mem_valid, and each request is followed by one idle cycle so the controller
// never sees the same request twice. All outputs are registered.
module dma_copy_engine #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [LEN_WIDTH-1:0]  words_done_o,
    dma_copy_engine_if.master     mem
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_RD_GAP = 3'd2;
    localparam logic [2:0] S_WR     = 3'd3;
    localparam logic [2:0] S_WR_GAP = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    // Counter wide enough to hold TIMEOUT_CYCLES itself.
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] buf_q, buf_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [LEN_WIDTH-1:0]  wdone_q, wdone_d;
    logic                  en_q, en_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  timeout;

    // A request that has waited TIMEOUT_CYCLES-1 cycles times out if this
    // cycle also passes without mem_valid.
    assign timeout = (tmo_q == TMO_LAST);

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        tmo_d   = tmo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        wdone_d = wdone_q;
        en_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (abort_i) begin
            // Abort wins over start and over a coinciding mem_valid.
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        error_d = 1'b0;
                        wdone_d = '0;
                        busy_d  = 1'b1;
                        if (len_i != '0) begin
                            src_d   = src_addr_i;
                            dst_d   = dst_addr_i;
                            rem_d   = len_i;
                            tmo_d   = '0;
                            state_d = S_RD;
                            en_d    = 1'b1;
                            addr_d  = src_addr_i;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
                S_RD: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (mem.mem_valid) begin
                        buf_d   = mem.mem_rdata;
                        state_d = S_RD_GAP;
                    end else if (timeout) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        en_d = 1'b1;
                    end
                end
                S_RD_GAP: begin
                    src_d   = src_q + ADDR_WIDTH'(1);
                    tmo_d   = '0;
                    state_d = S_WR;
                    en_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = dst_q;
                    wdata_d = buf_q;
                end
                S_WR: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (mem.mem_valid) begin
                        state_d = S_WR_GAP;
                    end else if (timeout) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        en_d = 1'b1;
                        wr_d = 1'b1;
                    end
                end
                S_WR_GAP: begin
                    dst_d   = dst_q + ADDR_WIDTH'(1);
                    wdone_d = wdone_q + LEN_WIDTH'(1);
                    rem_d   = rem_q - LEN_WIDTH'(1);
                    if (rem_q != LEN_WIDTH'(1)) begin
                        tmo_d   = '0;
                        state_d = S_RD;
                        en_d    = 1'b1;
                        addr_d  = src_q;
                    end else begin
                        state_d = S_FIN;
                    end
                end
                S_FIN: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset drops the request asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            wdone_q <= '0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            wdone_q <= wdone_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign words_done_o  = wdone_q;
    assign mem.mem_en    = en_q;
    assign mem.mem_wr_en = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Bench for dma_copy_engine: a main instance with a delay-programmable memory
// model and request scoreboard, plus a short-timeout instance whose writes are
// never answered.
module tb_dma_copy_engine;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, error;
    logic [15:0] words_done;
    logic        busy_t, done_t, error_t;
    logic [15:0] words_done_t;

    dma_copy_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_if ();
    dma_copy_engine_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) t_if ();

    dma_copy_engine #(.TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy), .done_o(done), .error_o(error),
        .words_done_o(words_done), .mem(m_if)
    );

    dma_copy_engine #(.TIMEOUT_CYCLES(8)) dut_t (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .src_addr_i(src), .dst_addr_i(dst), .len_i(len),
        .busy_o(busy_t), .done_o(done_t), .error_o(error_t),
        .words_done_o(words_done_t), .mem(t_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    req_t        exp_q[$];
    int          dly_q[$];
    logic [31:0] mem [logic [31:0]];
    int          nvalid   = 0;
    int          abort_at = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], ~a[15:0]};
    endfunction

    // Main memory model + scoreboard monitor, sampled on the falling edge.
    logic        prev_en = 1'b0;
    req_t        cur;
    int          cur_delay = 0;
    int          wcnt = 0;
    always @(negedge clk) begin
        req_t e;
        abort = 1'b0;
        m_if.mem_valid = 1'b0;
        if (m_if.mem_en) begin
            if (!prev_en) begin
                cur = '{m_if.mem_wr_en, m_if.mem_addr, m_if.mem_wdata};
                if (exp_q.size() == 0) begin
                    check("extra_req", {m_if.mem_wr_en, m_if.mem_addr}, 33'h1_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("req_wr", m_if.mem_wr_en, e.wr);
                    check("req_addr", m_if.mem_addr, e.addr);
                    if (e.wr) check("req_wdata", m_if.mem_wdata, e.data);
                end
                cur_delay = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                wcnt = 0;
            end else begin
                check("hold_wr", m_if.mem_wr_en, cur.wr);
                check("hold_addr", m_if.mem_addr, cur.addr);
                check("hold_wdata", m_if.mem_wdata, cur.data);
            end
            if (wcnt == cur_delay) begin
                m_if.mem_valid = 1'b1;
                nvalid++;
                if (m_if.mem_wr_en) mem[m_if.mem_addr] = m_if.mem_wdata;
                else m_if.mem_rdata = mem_rd(m_if.mem_addr);
                if (nvalid == abort_at) abort = 1'b1;
            end
            wcnt++;
        end
        prev_en = m_if.mem_en;
    end

    // Timeout instance: reads answered at once, writes never answered.
    always @(negedge clk) begin
        t_if.mem_valid = t_if.mem_en && !t_if.mem_wr_en;
        t_if.mem_rdata = 32'hC0DE_0000 ^ t_if.mem_addr;
    end

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, s + 32'(i), 32'h0});
            exp_q.push_back('{1'b1, d + 32'(i), mem_rd(s + 32'(i))});
        end
    endtask

    // Pulse start for one cycle; returns at the negedge of the first busy cycle.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk);
        src = s; dst = d; len = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc);
        cyc = 1;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1'b1);
    endtask

    task automatic check_mem(input string tag, input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            check(tag, mem_rd(d + 32'(i)), {s[15:0] + 16'(i), ~(s[15:0] + 16'(i))});
    endtask

    initial begin
        int cyc;
        int wr_cnt, ndone, done_cyc;
        logic err_at_done;
        logic [15:0] wd_at_done;

        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_words", words_done, 16'd0);
        check("rst_en", m_if.mem_en, 1'b0);
        check("rst_wr_en", m_if.mem_wr_en, 1'b0);
        check("rst_addr", m_if.mem_addr, 32'd0);
        check("rst_wdata", m_if.mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic copy of three words, every request granted at once.
        push_copy(32'h100, 32'h200, 3);
        do_start(32'h100, 32'h200, 16'd3);
        check("basic_busy", busy, 1'b1);
        wait_done(100, cyc);
        check("basic_latency", cyc, 14);
        check("basic_error", error, 1'b0);
        check("basic_words", words_done, 16'd3);
        @(negedge clk);
        check("basic_done_pulse", done, 1'b0);
        check("basic_busy_end", busy, 1'b0);
        check("basic_sb_empty", exp_q.size(), 0);
        check_mem("basic_mem", 32'h100, 32'h200, 3);
        repeat (20) @(negedge clk);

        // Grant stalls of 0, 5, 37 and 5 cycles.
        dly_q = '{0, 5, 37, 5};
        push_copy(32'h300, 32'h400, 2);
        do_start(32'h300, 32'h400, 16'd2);
        wait_done(200, cyc);
        check("stall_latency", cyc, 57);
        check("stall_words", words_done, 16'd2);
        check("stall_sb_empty", exp_q.size(), 0);
        check_mem("stall_mem", 32'h300, 32'h400, 2);
        repeat (20) @(negedge clk);

        // Zero length: one busy cycle, then done, no traffic.
        do_start(32'h10, 32'h20, 16'd0);
        check("zero_busy", busy, 1'b1);
        check("zero_done_early", done, 1'b0);
        check("zero_en", m_if.mem_en, 1'b0);
        @(negedge clk);
        check("zero_busy_end", busy, 1'b0);
        check("zero_done", done, 1'b1);
        check("zero_words", words_done, 16'd0);
        @(negedge clk);
        check("zero_done_pulse", done, 1'b0);
        repeat (20) @(negedge clk);

        // Source pointer wraps from all-ones to zero.
        push_copy(32'hFFFF_FFFF, 32'h500, 2);
        do_start(32'hFFFF_FFFF, 32'h500, 16'd2);
        wait_done(100, cyc);
        check("wrap_latency", cyc, 10);
        check("wrap_sb_empty", exp_q.size(), 0);
        check("wrap_mem0", mem_rd(32'h500), 32'hFFFF_0000);
        check("wrap_mem1", mem_rd(32'h501), 32'h0000_FFFF);
        repeat (20) @(negedge clk);

        // Timeout on the short-timeout instance's first write.
        push_copy(32'h600, 32'h700, 1);
        do_start(32'h600, 32'h700, 16'd1);
        wr_cnt = 0; ndone = 0; done_cyc = 0; err_at_done = 1'b0; wd_at_done = 16'hFFFF;
        for (int c = 1; c <= 30; c++) begin
            if (t_if.mem_en && t_if.mem_wr_en) wr_cnt++;
            if (done_t) begin
                ndone++; done_cyc = c; err_at_done = error_t; wd_at_done = words_done_t;
            end
            @(negedge clk);
        end
        check("tmo_wait_cycles", wr_cnt, 8);
        check("tmo_done_count", ndone, 1);
        check("tmo_done_cycle", done_cyc, 12);
        check("tmo_error", err_at_done, 1'b1);
        check("tmo_words", wd_at_done, 16'd0);
        check("tmo_en_low", t_if.mem_en, 1'b0);
        check("tmo_main_words", words_done, 16'd1);
        check("tmo_main_sb_empty", exp_q.size(), 0);
        push_copy(32'h610, 32'h710, 1);
        do_start(32'h610, 32'h710, 16'd1);
        check("tmo_error_cleared", error_t, 1'b0);
        check("tmo_restart_busy", busy_t, 1'b1);
        wait_done(100, cyc);
        repeat (20) @(negedge clk);

        // Abort coinciding with the third mem_valid (second read).
        exp_q.push_back('{1'b0, 32'h800, 32'h0});
        exp_q.push_back('{1'b1, 32'h900, mem_rd(32'h800)});
        exp_q.push_back('{1'b0, 32'h801, 32'h0});
        abort_at = nvalid + 3;
        do_start(32'h800, 32'h900, 16'd4);
        cyc = 1;
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_cycle", cyc, 6);
        check("abort_busy", busy, 1'b0);
        check("abort_en", m_if.mem_en, 1'b0);
        check("abort_words", words_done, 16'd1);
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);
        check("abort_error", error, 1'b0);
        check("abort_sb_empty", exp_q.size(), 0);
        check("abort_dst0", mem_rd(32'h900), mem_rd(32'h800));
        check("abort_dst1_unwritten", mem.exists(32'h901), 1'b0);
        repeat (20) @(negedge clk);

        // A second start while busy must not disturb the running copy.
        dly_q = '{3, 3, 3, 3};
        push_copy(32'hA00, 32'hB00, 2);
        do_start(32'hA00, 32'hB00, 16'd2);
        @(negedge clk);
        src = 32'hC00; dst = 32'hD00; len = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100, cyc);
        check("busy_start_words", words_done, 16'd2);
        @(negedge clk);
        check("busy_start_idle", busy, 1'b0);
        check("busy_start_sb_empty", exp_q.size(), 0);
        check("busy_start_no_d00", mem.exists(32'hD00), 1'b0);
        check_mem("busy_start_mem", 32'hA00, 32'hB00, 2);
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of a stalled write.
        dly_q = '{0, 30};
        push_copy(32'hE00, 32'hF00, 1);
        do_start(32'hE00, 32'hF00, 16'd1);
        cyc = 1;
        while (!(m_if.mem_en && m_if.mem_wr_en) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("arst_in_wr", m_if.mem_en && m_if.mem_wr_en, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_en", m_if.mem_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_wr_en", m_if.mem_wr_en, 1'b0);
        check("arst_addr", m_if.mem_addr, 32'd0);
        check("arst_wdata", m_if.mem_wdata, 32'd0);
        check("arst_words", words_done, 16'd0);
        check("arst_done", done, 1'b0);
        check("arst_error", error, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_stay_idle", {busy, m_if.mem_en}, 2'b00);
        check("arst_sb_empty", exp_q.size(), 0);
        check("arst_no_write", mem.exists(32'hF00), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
